// File: rtl/pe_nic_pkg.sv
// Shared constants for the processing-element network interface.
// Covers the processor register map, packet field positions and router polarity values.
package pe_nic_pkg;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    localparam int VC     = 63;
    localparam int DIR    = 62;
    localparam int HC_MSB = 55;
    localparam int HC_LSB = 48;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/nic_channel_reg.sv
// One-entry packet buffer with a full flag.
// When load and clr are both asserted, load wins.
module nic_channel_reg
    import pe_nic_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] buf_o,
    output logic         full_o
);

    logic [W-1:0] buf_d, buf_q;
    logic         full_d, full_q;

    // next-state for the buffer and its full flag
    always_comb begin
        buf_d  = buf_q;
        full_d = full_q;
        if (load) begin
            buf_d  = data_in;
            full_d = 1'b1;
        end else if (clr) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // state register, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q  <= {W{1'b0}};
            full_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            full_q <= full_d;
        end
    end

    assign buf_o  = buf_q;
    assign full_o = full_q;

endmodule

// File: rtl/pe_nic.sv
// Network interface between a processor register port and a router port.
// Holds one inbound and one outbound packet, and counts processor writes that are dropped.
module pe_nic
    import pe_nic_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_so,
    output logic              net_ro,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_si,
    input  logic              net_ri,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);

    logic              rd_en_s, wr_en_s;
    logic              in_load_s, in_clr_s, in_full_s;
    logic              out_load_s, out_full_s, drop_s;
    logic [DATA_W-1:0] in_buf_s, out_buf_s;
    logic [7:0]        drop_cnt_d, drop_cnt_q;

    assign rd_en_s = nicEn & ~nicWrEn;
    assign wr_en_s = nicEn & nicWrEn;

    // A pop and an inbound capture cannot share an edge, because net_ro is low while full.
    assign net_ro    = ~in_full_s;
    assign in_load_s = net_so & net_ro;
    assign in_clr_s  = rd_en_s & (addr == ADDR_IN_BUF) & in_full_s;

    // A write to a full output buffer is dropped, even when a send completes at the same edge.
    assign out_load_s = wr_en_s & (addr == ADDR_OUT_BUF) & ~out_full_s;
    assign drop_s     = wr_en_s & (addr == ADDR_OUT_BUF) & out_full_s;

    assign net_si = out_full_s & net_ri & (out_buf_s[VC] == net_polarity);
    assign net_do = out_buf_s;

    nic_channel_reg #(.W(DATA_W)) u_in_ch (
        .clk     (clk),
        .reset   (reset),
        .load    (in_load_s),
        .clr     (in_clr_s),
        .data_in (net_di),
        .buf_o   (in_buf_s),
        .full_o  (in_full_s)
    );

    nic_channel_reg #(.W(DATA_W)) u_out_ch (
        .clk     (clk),
        .reset   (reset),
        .load    (out_load_s),
        .clr     (net_si),
        .data_in (d_in),
        .buf_o   (out_buf_s),
        .full_o  (out_full_s)
    );

    // processor read mux; the output buffer is write-only and reads back as zero
    always_comb begin
        d_out = {DATA_W{1'b0}};
        if (rd_en_s) begin
            case (addr)
                ADDR_IN_BUF:   d_out = in_buf_s;
                ADDR_IN_STAT:  d_out = {{(DATA_W-1){1'b0}}, in_full_s};
                ADDR_OUT_BUF:  d_out = {DATA_W{1'b0}};
                ADDR_OUT_STAT: d_out = {{(DATA_W-1){1'b0}}, out_full_s};
                default:       d_out = {DATA_W{1'b0}};
            endcase
        end else begin
            d_out = {DATA_W{1'b0}};
        end
    end

    // saturating count of dropped outbound writes
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // drop counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: doc/pe_nic.md
PE_NIC -- requirements
Module: pe_nic

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 64, packet width.
- ADDR_W, default 2, processor register address width.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  2  processor register select.
- d_in  in  64  processor write data.
- d_out  out  64  processor read data.
- nicEn  in  1  processor access enable.
- nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
- net_so  in  1  router-to-NIC send (router peso).
- net_ro  out  1  NIC-to-router ready (router pero).
- net_di  in  64  router-to-NIC packet (router pedo).
- net_si  out  1  NIC-to-router send (router pesi).
- net_ri  in  1  router-to-NIC ready (router peri).
- net_do  out  64  NIC-to-router packet (router pedi).
- net_polarity  in  1  router polarity; 0 = even, 1 = odd.

Function
REQ-003 The block SHALL hold two one-entry channels:
- input channel: in_buf[63:0] with in_full;
- output channel: out_buf[63:0] with out_full.

REQ-004 The register map SHALL be:
- 00: in_buf, read-only;
- 01: in_full status, read-only, returned as {63'b0, in_full};
- 10: out_buf, write-only;
- 11: out_full status, read-only, returned as {63'b0, out_full}.

REQ-005 d_out SHALL be combinational:
- when nicEn=1 and nicWrEn=0, the mapped value for addr;
- otherwise 64'h0;
- a read of addr 10 SHALL return 64'h0.

REQ-006 A read of addr 00 while in_full=1 SHALL return in_buf in the same cycle and clear in_full at that clock edge. A read of addr 00 while in_full=0 SHALL return the stale in_buf and change no state.

REQ-007 A write to addr 10:
- when out_full=0: load out_buf from d_in and set out_full at that edge;
- when out_full=1: no effect, including when a send completes in the same cycle (status must be polled first).

REQ-008 Writes to addr 00, 01 and 11 SHALL have no effect.

REQ-009 net_ro SHALL equal !in_full combinationally.

REQ-010 Inbound transfer: when net_so=1 and net_ro=1 at a clock edge, in_buf SHALL capture net_di unmodified and in_full SHALL be set. Inbound latency SHALL be one edge, visible at addr 00 in the next cycle.

REQ-011 net_si SHALL equal out_full & net_ri & (out_buf[63] == net_polarity), combinationally. Bit 63 is the packet's virtual-channel bit.

REQ-012 net_do SHALL equal out_buf at all times. No hop-count (bits 55:48) or direction (bit 62) modification SHALL occur in the NIC.

REQ-013 At any edge where net_si=1, out_full SHALL clear. out_buf SHALL retain its value.

REQ-014 A processor read clearing in_full at the same edge as net_so=1 SHALL NOT capture the new packet, because net_ro was 0 in that cycle. The router retries.

REQ-015 The block SHALL count discarded writes:
- drop_cnt[7:0] increments on every write to addr 10 while out_full=1;
- it saturates at 8'hFF;
- it is observable only in simulation (hierarchical reference), not through ports.

Reset
REQ-016 While reset=0, asynchronously, all of the following SHALL hold:
- in_full=0, out_full=0, in_buf=0, out_buf=0, drop_cnt=0;
- hence net_si=0, net_ro=1, net_do=0, and d_out follows REQ-005.

REQ-017 Reset asserted mid-transfer SHALL discard both channels, with no partial packet retained.

REQ-018 The first state update after reset deassertion SHALL occur at the next rising clk edge.

Structure
REQ-019 A shared package SHALL hold:
- address constants ADDR_IN_BUF=2'b00, ADDR_IN_STAT=2'b01, ADDR_OUT_BUF=2'b10, ADDR_OUT_STAT=2'b11;
- packet field positions VC=63, DIR=62, HC=55:48;
- EVEN=1'b0, ODD=1'b1.

REQ-020 One sub-module, nic_channel_reg, SHALL implement a 64-bit one-entry buffer with full flag, load and clear. It SHALL be instantiated twice (input and output channels). Address decode and handshake logic SHALL stay in pe_nic.

Verification
REQ-021 Reset: hold reset=0 for 3 cycles -> net_ro=1, net_si=0, net_do=0, and a read of addr 01 returns 0.

REQ-022 Inbound: drive net_so=1 with net_di=64'h0003_0000_0000_00AA -> next cycle net_ro=0 and addr 01 reads 1. Reading addr 00 returns 64'h0003_0000_0000_00AA, then addr 01 reads 0.

REQ-023 Outbound with polarity gating: write 64'h8000_0000_0000_0055 (VC=1) with net_ri=1 and net_polarity=0 -> net_si=0. On the next cycle, with net_polarity=1 -> net_si=1, and out_full clears after that edge.

REQ-024 Backpressure: hold out_full=1, net_ri=0 for 10 cycles -> net_si=0 throughout. A second write of 64'h1 is dropped: out_buf unchanged and drop_cnt=1.

REQ-025 Full input: with in_full=1, hold net_so=1 -> in_buf unchanged. A read of addr 00 clears in_full; net_ro rises the next cycle and the pending packet is captured one edge later.

REQ-026 Mid-operation reset: with both channels full, pulse reset=0 between edges -> both status reads return 0 immediately after release, with no clock edge required.
